// File: rtl/control_suma_resta_if.sv
// Request/grant, complementer and result signals of the shared add/subtract controller.
// The master side holds the requesters and the complementer; the slave side is the controller.
interface control_suma_resta_if #(
    parameter int ANCHO = 4
);
    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [ANCHO-1:0] a0;
    logic [ANCHO-1:0] b0;
    logic [ANCHO-1:0] a1;
    logic [ANCHO-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             sumar;
    logic             restar;
    logic [ANCHO-1:0] entM;
    logic [ANCHO-1:0] complement;
    logic [ANCHO-1:0] resultado;
    logic             acarreo;
    logic             desborde;
    logic             id;
    logic             listo;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, complement,
        input  gnt0, gnt1, sumar, restar, entM, resultado, acarreo, desborde, id, listo
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, complement,
        output gnt0, gnt1, sumar, restar, entM, resultado, acarreo, desborde, id, listo
    );
endinterface

// File: rtl/control_suma_resta.sv
// Round-robin controller for the shared add/subtract datapath: grant, complement, add, done.
// Latency: listo two edges after the grant edge; one operation per 4 cycles, requests held until gnt.
module control_suma_resta #(
    parameter int ANCHO = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    control_suma_resta_if.slave  bus
);
    localparam logic [1:0] REPOSO = 2'd0;
    localparam logic [1:0] COMPL  = 2'd1;
    localparam logic [1:0] SUMA   = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;
    localparam int         MSB    = ANCHO - 1;

    logic [1:0]       r_estado;
    logic             r_ultimo;
    logic             r_id_int;
    logic             r_op;
    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_b;
    logic [ANCHO-1:0] r_beff;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_sumar;
    logic             r_restar;
    logic [ANCHO-1:0] r_entM;
    logic [ANCHO-1:0] r_resultado;
    logic             r_acarreo;
    logic             r_desborde;
    logic             r_id;
    logic             r_listo;

    logic             w_any;
    logic             w_sel1;
    logic             w_op_in;
    logic [ANCHO-1:0] w_a_in;
    logic [ANCHO-1:0] w_b_in;
    logic [ANCHO:0]   w_suma;
    logic             w_desborde;

    // On a tie the requester that was not granted last wins.
    assign w_any   = bus.req0 | bus.req1;
    assign w_sel1  = bus.req1 & (~bus.req0 | ~r_ultimo);
    assign w_op_in = w_sel1 ? bus.op1 : bus.op0;
    assign w_a_in  = w_sel1 ? bus.a1  : bus.a0;
    assign w_b_in  = w_sel1 ? bus.b1  : bus.b0;

    // Overflow uses the original B so that subtracting the most negative value is flagged.
    assign w_suma     = {1'b0, r_a} + {1'b0, r_beff};
    assign w_desborde = r_op ? ((r_a[MSB] != r_b[MSB]) && (w_suma[MSB] != r_a[MSB]))
                             : ((r_a[MSB] == r_b[MSB]) && (w_suma[MSB] != r_a[MSB]));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado    <= REPOSO;
            r_ultimo    <= 1'b1;
            r_id_int    <= 1'b0;
            r_op        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_beff      <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_sumar     <= 1'b0;
            r_restar    <= 1'b0;
            r_entM      <= '0;
            r_resultado <= '0;
            r_acarreo   <= 1'b0;
            r_desborde  <= 1'b0;
            r_id        <= 1'b0;
            r_listo     <= 1'b0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_sumar  <= 1'b0;
            r_restar <= 1'b0;
            r_entM   <= '0;
            r_listo  <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (w_any) begin
                        r_a      <= w_a_in;
                        r_b      <= w_b_in;
                        r_op     <= w_op_in;
                        r_ultimo <= w_sel1;
                        r_id_int <= w_sel1;
                        r_gnt0   <= ~w_sel1;
                        r_gnt1   <= w_sel1;
                        r_sumar  <= ~w_op_in;
                        r_restar <= w_op_in;
                        r_entM   <= w_b_in;
                        r_estado <= COMPL;
                    end
                end
                COMPL: begin
                    r_beff   <= bus.complement;
                    r_estado <= SUMA;
                end
                SUMA: begin
                    r_resultado <= w_suma[ANCHO-1:0];
                    r_acarreo   <= w_suma[ANCHO];
                    r_desborde  <= w_desborde;
                    r_id        <= r_id_int;
                    r_listo     <= 1'b1;
                    r_estado    <= FIN;
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.sumar     = r_sumar;
    assign bus.restar    = r_restar;
    assign bus.entM      = r_entM;
    assign bus.resultado = r_resultado;
    assign bus.acarreo   = r_acarreo;
    assign bus.desborde  = r_desborde;
    assign bus.id        = r_id;
    assign bus.listo     = r_listo;
endmodule

// File: tb/tb_control_suma_resta.sv
// Directed bench for control_suma_resta with a behavioural complementer.
module tb_control_suma_resta;
    localparam int ANCHO = 4;

    typedef struct {
        logic       sel;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_res;
        logic       exp_c;
        logic       exp_v;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_suma_resta_if #(.ANCHO(ANCHO)) bus ();
    control_suma_resta #(.ANCHO(ANCHO)) dut (.clk(clk), .reset(reset), .bus(bus));

    always_comb begin
        if (bus.restar)     bus.complement = 4'(~bus.entM + 4'd1);
        else if (bus.sumar) bus.complement = bus.entM;
        else                bus.complement = 4'd0;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " outputs"},
            {bus.gnt0, bus.gnt1, bus.sumar, bus.restar, bus.acarreo, bus.desborde, bus.id, bus.listo}, 8'h00);
        chk({tag, " entM"}, {4'd0, bus.entM}, 8'h00);
        chk({tag, " resultado"}, {4'd0, bus.resultado}, 8'h00);
    endtask

    // Wait (bounded) for the grant of requester sel; returns 1 if seen.
    task automatic wait_gnt(input logic sel, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if ((sel && bus.gnt1) || (!sel && bus.gnt0)) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gnt%0d timeout actual=0 required=1", sel);
        end
    endtask

    task automatic do_op(input vec_t v, input int n);
        bit    seen;
        string t;
        t = $sformatf("v%0d", n);
        @(negedge clk);
        if (v.sel) begin bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b; end
        else       begin bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b; end
        wait_gnt(v.sel, seen);
        if (seen) begin
            chk({t, " other gnt"}, {7'd0, v.sel ? bus.gnt0 : bus.gnt1}, 8'h00);
            chk({t, " sumar/restar"}, {6'd0, bus.sumar, bus.restar}, {6'd0, ~v.op, v.op});
            chk({t, " entM"}, {4'd0, bus.entM}, {4'd0, v.b});
            // Release the request and scramble operands: the operation in flight must not notice.
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            bus.a0 = ~v.a; bus.b0 = v.a; bus.a1 = ~v.a; bus.b1 = v.a;
            bus.op0 = ~v.op; bus.op1 = ~v.op;
            tick();
            chk({t, " k+1 gnt/listo/ctl"}, {4'd0, bus.gnt0, bus.gnt1, bus.listo, bus.sumar | bus.restar}, 8'h00);
            tick();
            chk({t, " listo"}, {7'd0, bus.listo}, 8'h01);
            chk({t, " resultado"}, {4'd0, bus.resultado}, {4'd0, v.exp_res});
            chk({t, " acarreo"}, {7'd0, bus.acarreo}, {7'd0, v.exp_c});
            chk({t, " desborde"}, {7'd0, bus.desborde}, {7'd0, v.exp_v});
            chk({t, " id"}, {7'd0, bus.id}, {7'd0, v.sel});
            tick();
            chk({t, " listo drop"}, {7'd0, bus.listo}, 8'h00);
            chk({t, " resultado hold"}, {4'd0, bus.resultado}, {4'd0, v.exp_res});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    vec_t vecs[8];
    int   gnt_id[$];
    int   gnt_cyc[$];

    initial begin
        bit seen;
        int both;
        int listos;

        vecs[0] = '{1'b0, 1'b0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1};

        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        tick();
        tick();
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Reset during COMPL aborts the operation.
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.a0 = 4'b0011; bus.b0 = 4'b0100;
        wait_gnt(1'b0, seen);
        bus.req0 = 1'b0;
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        listos = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.listo) listos++;
        end
        chk("aborted listo count", 8'(listos), 8'd0);

        for (int i = 0; i < 8; i++) do_op(vecs[i], i);

        // Round-robin with both requests held high from reset.
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.op0 = 1'b0; bus.op1 = 1'b1;
        bus.a0 = 4'd1; bus.b0 = 4'd2; bus.a1 = 4'd5; bus.b1 = 4'd3;
        both = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (bus.gnt0 && bus.gnt1) both++;
            if (bus.gnt0) begin gnt_id.push_back(0); gnt_cyc.push_back(c); end
            else if (bus.gnt1) begin gnt_id.push_back(1); gnt_cyc.push_back(c); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr simultaneous", 8'(both), 8'd0);
        chk("rr grant count", 8'(gnt_id.size()), 8'd6);
        for (int i = 0; i < gnt_id.size(); i++) begin
            chk($sformatf("rr order %0d", i), 8'(gnt_id[i]), 8'(i % 2));
            if (i > 0) chk($sformatf("rr spacing %0d", i), 8'(gnt_cyc[i] - gnt_cyc[i-1]), 8'd4);
        end
        tick();
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
